// File: rtl/shift_pipelined_multimode.sv
// rtl/shift_pipelined_multimode.sv - multi-mode pipelined barrel shifter with ready/valid flow control
// Each stage resolves RADIX_BITS of the shift; left shifts ride the right-shift path bit-reversed.
module shift_pipelined_multimode #(
  parameter int WIDTH      = 13,
  parameter int RADIX_BITS = 2,
  parameter int TAG_WIDTH  = 4,
  localparam int SW        = $clog2(WIDTH),
  localparam int STAGES    = (SW + RADIX_BITS - 1) / RADIX_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     data_i,
  input  logic [SW-1:0]        shift_i,
  input  logic [1:0]           mode_i,
  input  logic [TAG_WIDTH-1:0] tag_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [WIDTH-1:0]     data_o,
  output logic [TAG_WIDTH-1:0] tag_o,
  output logic                 ovf_o,
  output logic                 valid_o,
  input  logic                 ready_i
);
  localparam int          PW   = STAGES * RADIX_BITS;
  localparam int          L    = STAGES - 1;
  localparam logic [SW:0] WLIM = (SW + 1)'(WIDTH);

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
    return r;
  endfunction

  logic [WIDTH-1:0]     data_q  [STAGES];
  logic [1:0]           mode_q  [STAGES];
  logic [TAG_WIDTH-1:0] tag_q   [STAGES];
  logic                 ovf_q   [STAGES];
  logic                 valid_q [STAGES];
  logic [STAGES-1:0]    vld;
  logic [STAGES-1:0]    adv;

  logic                 in_ovf;
  logic                 in_fill;
  logic [WIDTH-1:0]     in_data;
  logic [SW-1:0]        in_shamt;

  // Out-of-range words get their final value up front and travel with a zero shift.
  always_comb begin
    in_ovf   = {1'b0, shift_i} >= WLIM;
    in_fill  = (mode_i == 2'd2) && data_i[WIDTH-1];
    in_data  = (mode_i == 2'd1) ? bit_rev(data_i) : data_i;
    in_shamt = shift_i;
    if (in_ovf) begin
      in_data  = {WIDTH{in_fill}};
      in_shamt = '0;
    end
  end

  always_comb begin
    vld = '0;
    for (int s = 0; s < STAGES; s++) vld[s] = valid_q[s];
  end

  // A stage may load when every stage from it to the output is full only if the output drains.
  for (genvar s = 0; s < STAGES; s++) begin : g_adv
    assign adv[s] = ready_i || !(&vld[L:s]);
  end

  assign ready_o = rst_n && adv[0];

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [WIDTH-1:0]     src_data;
    logic [SW-1:0]        src_shamt;
    logic [1:0]           src_mode;
    logic [TAG_WIDTH-1:0] src_tag;
    logic                 src_fill;
    logic                 src_ovf;
    logic                 src_valid;
    logic [PW-1:0]        pad;
    logic [RADIX_BITS-1:0] digit;
    int                   amt;
    logic [2*WIDTH-1:0]   ext;
    logic [WIDTH-1:0]     data_d;

    if (s == 0) begin : g_src
      assign src_data  = in_data;
      assign src_shamt = in_shamt;
      assign src_mode  = mode_i;
      assign src_tag   = tag_i;
      assign src_fill  = in_fill;
      assign src_ovf   = in_ovf;
      assign src_valid = valid_i;
    end else begin : g_src
      assign src_data  = data_q[s-1];
      assign src_shamt = g_stage[s-1].g_carry.shamt_q;
      assign src_mode  = mode_q[s-1];
      assign src_tag   = tag_q[s-1];
      assign src_fill  = g_stage[s-1].g_carry.fill_q;
      assign src_ovf   = ovf_q[s-1];
      assign src_valid = valid_q[s-1];
    end

    always_comb begin
      pad    = PW'(src_shamt);
      digit  = RADIX_BITS'(pad >> (s * RADIX_BITS));
      amt    = int'(digit) << (s * RADIX_BITS);
      ext    = (src_mode == 2'd3) ? {src_data, src_data} : {{WIDTH{src_fill}}, src_data};
      data_d = WIDTH'(ext >> amt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q[s] <= 1'b0;
        data_q[s]  <= '0;
        mode_q[s]  <= '0;
        tag_q[s]   <= '0;
        ovf_q[s]   <= 1'b0;
      end else if (adv[s]) begin
        valid_q[s] <= src_valid;
        data_q[s]  <= data_d;
        mode_q[s]  <= src_mode;
        tag_q[s]   <= src_tag;
        ovf_q[s]   <= src_ovf;
      end
    end

    // The final stage has no consumer for the shift amount or fill bit.
    if (s < L) begin : g_carry
      logic [SW-1:0] shamt_q;
      logic          fill_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          shamt_q <= '0;
          fill_q  <= 1'b0;
        end else if (adv[s]) begin
          shamt_q <= src_shamt;
          fill_q  <= src_fill;
        end
      end
    end
  end

  assign data_o  = (mode_q[L] == 2'd1) ? bit_rev(data_q[L]) : data_q[L];
  assign tag_o   = tag_q[L];
  assign ovf_o   = ovf_q[L];
  assign valid_o = valid_q[L];
endmodule
